// File: rtl/fir_decim_4_serializer_pkg.sv
// Shared types for the decimate-by-4 FIR output serializer: channel geometry,
// packed frame type and read-side FSM states.
package fir_decim_4_pkg;

  localparam int NCH = 4;
  localparam int SW  = 18;

  // Channel k occupies bits [SW*k+SW-1 : SW*k] of the flat frame.
  typedef logic [NCH-1:0][SW-1:0] frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/fir_decim_4_serializer_if.sv
// Frame-in / sample-out bundle for the serializer. The master side is the
// serializer itself: it consumes FIR frames and sources the sample stream.
interface fir_decim_4_serializer_if;
  import fir_decim_4_pkg::*;

  frame_t        id;
  logic          iv;
  logic [SW-1:0] od;
  logic [1:0]    och;
  logic          olast;
  logic          ov;
  logic          ordy;

  modport master (
    input  id, iv, ordy,
    output od, och, olast, ov
  );

  modport slave (
    output id, iv, ordy,
    input  od, och, olast, ov
  );

endinterface

// File: rtl/fir_frame_fifo.sv
// Frame FIFO with look-ahead read of the head and the frame behind it.
// A write is still taken when full if the head is popped in the same cycle.
module fir_frame_fifo
  import fir_decim_4_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        c,
  input  logic        reset,
  input  logic        wr,
  input  frame_t      wdata,
  input  logic        rd,
  output logic        wr_accept,
  output logic [AW:0] count,
  output frame_t      head,
  output frame_t      head_next
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  frame_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Fullness is judged after this cycle's pop.
  assign wr_accept = wr && ((count < FULL) || rd);

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + 1'b1];

  always_ff @(posedge c) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge c) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd)        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_4_serializer.sv
// Captures 4-channel FIR frames into a frame FIFO and replays each one as four
// channel-tagged samples on a valid/ready stream; overflowing frames are dropped.
//
//   state | meaning
//   IDLE  | no frame buffered, ov low
//   SEND  | od/och hold a sample of the head frame, ov high
module fir_decim_4_serializer
  import fir_decim_4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                         c,
  input  logic                         reset,
  fir_decim_4_serializer_if.master     bus,
  output logic [CW-1:0]                ovf_count,
  output logic                         ovf
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] od_q;
  logic [SW-1:0] od_n;
  logic [1:0]    och_q;
  logic [1:0]    och_n;
  logic          olast_q;

  logic          pop;
  logic          xfer;
  logic          more;
  logic          drop;
  logic          wr_accept;
  logic [AW:0]   fifo_count;
  frame_t        head;
  frame_t        head_next;

  fir_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .c         (c),
    .reset     (reset),
    .wr        (bus.iv),
    .wdata     (bus.id),
    .rd        (pop),
    .wr_accept (wr_accept),
    .count     (fifo_count),
    .head      (head),
    .head_next (head_next)
  );

  assign xfer = (state == SEND) && bus.ordy;
  // Another frame follows the popped head, possibly the one arriving now.
  assign more = (fifo_count > ONE) || wr_accept;
  assign drop = bus.iv && !wr_accept;

  always_ff @(posedge c) begin
    if (reset) begin
      state     <= IDLE;
      od_q      <= '0;
      och_q     <= '0;
      olast_q   <= 1'b0;
      ovf_count <= '0;
      ovf       <= 1'b0;
    end else begin
      state   <= state_n;
      od_q    <= od_n;
      och_q   <= och_n;
      olast_q <= (och_n == 2'd3);
      if (drop) begin
        ovf <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + CW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (fifo_count != '0) state_n = SEND;
      SEND:    if (xfer && (och_q == 2'd3) && !more) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    od_n  = od_q;
    och_n = och_q;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          od_n  = head[0];
          och_n = 2'd0;
        end
      end
      SEND: begin
        if (xfer) begin
          if (och_q != 2'd3) begin
            och_n = och_q + 2'd1;
            od_n  = head[och_q + 2'd1];
          end else begin
            pop   = 1'b1;
            och_n = 2'd0;
            if (fifo_count > ONE) od_n = head_next[0];
            else if (wr_accept)   od_n = bus.id[0];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ov    = (state == SEND);
  assign bus.od    = od_q;
  assign bus.och   = och_q;
  assign bus.olast = olast_q;

endmodule

// File: tb/tb_fir_decim_4_serializer.sv
// Randomised bench for the FIR frame serializer: a queue-of-frames model predicts
// every transferred sample, drop count and hold behaviour; literal checks pin timing.
module tb_fir_decim_4_serializer;

  localparam int DEPTH = 4;
  typedef logic [3:0][17:0] tb_frame_t;

  logic c = 1'b0;
  logic reset;
  always #5 c = ~c;

  fir_decim_4_serializer_if bus ();
  fir_decim_4_serializer_if bus2 ();

  logic [15:0] ovf_count;
  logic        ovf;
  logic [3:0]  ovf_count2;
  logic        ovf2;

  fir_decim_4_serializer #(.DEPTH(DEPTH), .CW(16)) dut (
    .c(c), .reset(reset), .bus(bus), .ovf_count(ovf_count), .ovf(ovf)
  );

  // Same frames, never drained, narrow counter: exercises saturation.
  fir_decim_4_serializer #(.DEPTH(DEPTH), .CW(4)) dut2 (
    .c(c), .reset(reset), .bus(bus2), .ovf_count(ovf_count2), .ovf(ovf2)
  );
  assign bus2.id   = bus.id;
  assign bus2.iv   = bus.iv;
  assign bus2.ordy = 1'b0;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int drops = 0;
  int head_ch = 0;
  tb_frame_t q[$];

  logic        prev_valid = 1'b0;
  logic        prev_ov, prev_ordy;
  logic [17:0] prev_od;
  logic [1:0]  prev_och;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: accepted frames in arrival order, head included until its ch3 leaves.
  always @(posedge c) begin
    if (reset) begin
      q.delete();
      head_ch    = 0;
      drops      = 0;
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && prev_ov && !prev_ordy) begin
        chk("hold_ov", 32'(bus.ov), 1);
        chk("hold_od", 32'(bus.od), 32'(prev_od));
        chk("hold_och", 32'(bus.och), 32'(prev_och));
      end
      if (bus.ov && bus.ordy) begin
        if (q.size() == 0) begin
          chk("spurious_sample", 32'(bus.ov), 0);
        end else begin
          chk("od", 32'(bus.od), 32'(q[0][head_ch]));
          chk("och", 32'(bus.och), head_ch);
          xfers++;
          head_ch++;
          if (head_ch == 4) begin
            void'(q.pop_front());
            head_ch = 0;
          end
        end
      end
      if (bus.iv) begin
        if (q.size() < DEPTH) q.push_back(bus.id);
        else drops++;
      end
      prev_valid = 1'b1;
      prev_ov    = bus.ov;
      prev_ordy  = bus.ordy;
      prev_od    = bus.od;
      prev_och   = bus.och;
    end
  end

  always @(negedge c) begin
    if (!reset) begin
      chk("ovf_count", 32'(ovf_count), (drops > 65535) ? 65535 : drops);
      chk("ovf", 32'(ovf), 32'(drops != 0));
      if (bus.ov) chk("olast", 32'(bus.olast), 32'(head_ch == 3));
    end
  end

  task automatic tick(input int n, input bit rnd);
    repeat (n) begin
      @(negedge c);
      if (rnd) bus.ordy = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic tb_frame_t rand_frame();
    tb_frame_t f;
    for (int k = 0; k < 4; k++) f[k] = 18'($urandom);
    return f;
  endfunction

  task automatic send(input tb_frame_t f, input bit rnd);
    @(negedge c);
    bus.iv = 1'b1;
    bus.id = f;
    if (rnd) bus.ordy = 1'($urandom_range(0, 1));
    @(negedge c);
    bus.iv = 1'b0;
    if (rnd) bus.ordy = 1'($urandom_range(0, 1));
    tick(14, rnd);
  endtask

  task automatic do_reset();
    @(negedge c);
    reset  = 1'b1;
    bus.iv = 1'b0;
    @(negedge c);
    @(negedge c);
    reset = 1'b0;
  endtask

  task automatic wait_och(input logic [1:0] ch, output bit found);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge c);
      if (bus.ov && bus.och == ch) found = 1'b1;
    end
    if (!found) chk("wait_och_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp1 [4];
    tb_frame_t   f;
    int          x0;
    bit          found;

    reset    = 1'b1;
    bus.iv   = 1'b0;
    bus.id   = '0;
    bus.ordy = 1'b0;

    // Reset values and single-frame latency with literal samples.
    do_reset();
    chk("rst_ov", 32'(bus.ov), 0);
    chk("rst_od", 32'(bus.od), 0);
    chk("rst_och", 32'(bus.och), 0);
    chk("rst_olast", 32'(bus.olast), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    chk("rst_ovf", 32'(ovf), 0);
    bus.ordy = 1'b1;
    exp1 = '{18'h00001, 18'h3FFFF, 18'h1FFFF, 18'h20000};
    for (int k = 0; k < 4; k++) f[k] = exp1[k];
    @(negedge c);
    bus.iv = 1'b1;
    bus.id = f;
    @(negedge c);
    bus.iv = 1'b0;
    chk("lat_ov_t1", 32'(bus.ov), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge c);
      chk("lit_ov", 32'(bus.ov), 1);
      chk("lit_och", 32'(bus.och), k);
      chk("lit_od", 32'(bus.od), 32'(exp1[k]));
      chk("lit_olast", 32'(bus.olast), 32'(k == 3));
    end
    @(negedge c);
    chk("lit_ov_end", 32'(bus.ov), 0);
    tick(10, 1'b0);

    // 20 frames at the maximum rate with ordy high: nothing dropped.
    x0 = xfers;
    for (int i = 0; i < 20; i++) send(rand_frame(), 1'b0);
    tick(10, 1'b0);
    chk("burst_samples", xfers - x0, 80);
    chk("burst_ovf_count", 32'(ovf_count), 0);
    chk("burst_ovf", 32'(ovf), 0);
    chk("sat_ovf_count2", 32'(ovf_count2), 15);
    chk("sat_ovf2", 32'(ovf2), 1);

    // Stalled output: four frames retained, fifth dropped.
    do_reset();
    bus.ordy = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_frame(), 1'b0);
    chk("stall_ovf_count", 32'(ovf_count), 1);
    chk("stall_ovf", 32'(ovf), 1);
    x0 = xfers;
    bus.ordy = 1'b1;
    tick(30, 1'b0);
    chk("stall_samples", xfers - x0, 16);

    // Random backpressure over 64 frames.
    do_reset();
    x0 = xfers;
    for (int i = 0; i < 64; i++) send(rand_frame(), 1'b1);
    bus.ordy = 1'b1;
    tick(40, 1'b0);
    chk("rand_samples", xfers - x0, 4 * (64 - drops));

    // Full FIFO, head at ch3 transferring while a new frame arrives.
    do_reset();
    bus.ordy = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_frame(), 1'b0);
    x0 = xfers;
    @(negedge c);
    bus.ordy = 1'b1;
    wait_och(2'd3, found);
    if (found) begin
      bus.iv = 1'b1;
      bus.id = rand_frame();
      @(negedge c);
      bus.iv = 1'b0;
      chk("fullpop_ovf_count", 32'(ovf_count), 0);
    end
    tick(30, 1'b0);
    chk("fullpop_samples", xfers - x0, found ? 20 : 16);

    // Reset mid-frame with two frames queued.
    do_reset();
    bus.ordy = 1'b0;
    send(rand_frame(), 1'b0);
    send(rand_frame(), 1'b0);
    @(negedge c);
    bus.ordy = 1'b1;
    wait_och(2'd1, found);
    reset = 1'b1;
    @(negedge c);
    chk("midrst_ov", 32'(bus.ov), 0);
    chk("midrst_och", 32'(bus.och), 0);
    reset = 1'b0;
    x0 = xfers;
    send(rand_frame(), 1'b0);
    send(rand_frame(), 1'b0);
    tick(10, 1'b0);
    chk("midrst_samples", xfers - x0, 8);
    chk("midrst_ovf_count", 32'(ovf_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
